// File: rtl/accel_pkg.sv
// Shared definitions for the editing-accelerator controllers: frame FSM states,
// error codes and counter sizing.
package accel_pkg;

    localparam int CNT_W     = 10;
    localparam int FRAME_MAX = 800;
    localparam int TIMEOUT   = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_OUT,
        ST_DONE
    } frame_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TLAST   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // A frame length is legal when it is in 1..max_len.
    function automatic logic len_ok(input logic [CNT_W-1:0] len, input int max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting watchdog: load sets the count, enable decrements, expire flags
// the last enabled cycle before the count would pass zero.
module cycle_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/dma_frame_ctrl.sv
// Frame sequencer: loads one frame from MM2S into the core, then waits for the
// output buffer to drain to S2MM before allowing the next frame.
module dma_frame_ctrl #(
    parameter int FRAME_MAX = accel_pkg::FRAME_MAX,
    parameter int TIMEOUT   = accel_pkg::TIMEOUT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [9:0]  cfg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [9:0]  out_words,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        core_valid,
    output logic [31:0] core_data,
    output logic        core_last,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast
);

    import accel_pkg::*;

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    frame_state_e     state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] out_words_q, out_words_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             core_valid_q, core_valid_d;
    logic [31:0]      core_data_q, core_data_d;
    logic             core_last_q, core_last_d;

    logic tmr_load, tmr_en, tmr_expire;
    logic s_hs, m_hs, last_word;

    cycle_timer #(
        .WIDTH(TMR_W)
    ) u_watchdog (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(TIMEOUT - 1)),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    assign s_hs      = (state_q == ST_LOAD) && s_axis_tvalid;
    assign m_hs      = mon_tvalid && mon_tready;
    assign last_word = (in_cnt_q == len_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            out_words_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            core_valid_q <= 1'b0;
            core_data_q  <= '0;
            core_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            out_words_q  <= out_words_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            core_valid_q <= core_valid_d;
            core_data_q  <= core_data_d;
            core_last_q  <= core_last_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        out_words_d  = out_words_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        core_valid_d = 1'b0;
        core_data_d  = core_data_q;
        core_last_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok(cfg_len, FRAME_MAX)) begin
                        len_d      = cfg_len;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                        in_cnt_d   = '0;
                        out_cnt_d  = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        if (!err_q) err_code_d = ERR_LEN;
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (s_hs) begin
                    core_valid_d = 1'b1;
                    core_data_d  = s_axis_tdata;
                    if (last_word || s_axis_tlast) begin
                        core_last_d = 1'b1;
                        tmr_load    = 1'b1;
                        state_d     = ST_WAIT_OUT;
                        // Missing tlast on the final word or tlast before it.
                        if (last_word != s_axis_tlast) begin
                            if (!err_q) err_code_d = ERR_TLAST;
                            err_d = 1'b1;
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_OUT: begin
                tmr_en = 1'b1;
                if (m_hs) out_cnt_d = out_cnt_q + 1'b1;
                if (m_hs && mon_tlast) begin
                    state_d = ST_DONE;
                end else if (tmr_expire) begin
                    if (!err_q) err_code_d = ERR_TIMEOUT;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                out_words_d = out_cnt_q;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign s_axis_tready = (state_q == ST_LOAD);
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign out_words     = out_words_q;
    assign core_valid    = core_valid_q;
    assign core_data     = core_data_q;
    assign core_last     = core_last_q;

endmodule

// File: tb/tb_dma_frame_ctrl.sv
// Randomized frame-level bench for dma_frame_ctrl; expected core beats, error
// codes, done timing and word counts come from a frame model kept here.
module tb_dma_frame_ctrl;

    localparam int FRAME_MAX = 800;
    localparam int TMO       = 1024;

    logic        clk, rstn, start;
    logic [9:0]  cfg_len;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [9:0]  out_words;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0] s_axis_tdata;
    logic        core_valid, core_last;
    logic [31:0] core_data;
    logic        mon_tvalid, mon_tready, mon_tlast;

    dma_frame_ctrl #(
        .FRAME_MAX(FRAME_MAX),
        .TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .out_words    (out_words),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .core_valid   (core_valid),
        .core_data    (core_data),
        .core_last    (core_last),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tlast    (mon_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    done_cnt;

    always @(negedge clk) begin
        if (core_valid) got_q.push_back({core_last, core_data});
        if (done) done_cnt++;
    end

    task automatic do_start(input logic [9:0] len);
        @(negedge clk);
        start   = 1'b1;
        cfg_len = len;
        @(negedge clk);
        start   = 1'b0;
        cfg_len = 10'($urandom);
    endtask

    // Offers n_send words with random gaps; the model expects the first n_fwd
    // of them on the core side, the n_fwd-th flagged last.
    task automatic send_frame(input int n_send, input int tlast_at, input int n_fwd);
        int idx = 0;
        int guard = 0;
        logic [31:0] w = $urandom;
        while (idx < n_send && guard < 5000) begin
            @(negedge clk);
            guard++;
            s_axis_tvalid = ($urandom_range(3) != 0);
            s_axis_tdata  = w;
            s_axis_tlast  = (idx + 1 == tlast_at);
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back({(idx + 1 == n_fwd), w});
                idx++;
                w = $urandom;
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        n_checks++;
        if (idx !== n_send) begin
            n_fail++;
            $display("FAIL input_accept: accepted %0d words, required %0d", idx, n_send);
        end
    endtask

    // Drives n_out output-side handshakes; returns the negedge index where done
    // was first seen and the index of the final handshake.
    task automatic drain(input int n_out, input bit use_tlast, output int n_done, output int n_last);
        int cnt = 0;
        n_done = -1;
        n_last = -1;
        for (int n = 0; n < 3000; n++) begin
            if (done) begin
                n_done = n;
                break;
            end
            if (cnt < n_out) begin
                mon_tvalid = ($urandom_range(15) != 0);
                mon_tready = ($urandom_range(15) != 0);
                mon_tlast  = use_tlast && (cnt + 1 == n_out);
                if (mon_tvalid && mon_tready) begin
                    cnt++;
                    if (cnt == n_out) n_last = n;
                end
            end else begin
                mon_tvalid = 1'b0;
                mon_tready = 1'b0;
                mon_tlast  = 1'b0;
            end
            @(negedge clk);
        end
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    // Called in the DONE cycle: checks completion timing, status and core stream.
    task automatic finish_frame(input string name, input logic [1:0] exp_code, input int exp_words,
                                input int n_done, input int exp_n_done);
        int n;
        n_checks++;
        if (n_done !== exp_n_done) begin
            n_fail++;
            $display("FAIL %s done_timing: done at %0d, required %0d", name, n_done, exp_n_done);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s idle_after_done: busy/done=%b, required 00", name, {busy, done});
        end
        n_checks++;
        if (out_words !== 10'(exp_words)) begin
            n_fail++;
            $display("FAIL %s out_words: got %0d, required %0d", name, out_words, exp_words);
        end
        n_checks++;
        if ({err, err_code} !== {(exp_code != 2'b00), exp_code}) begin
            n_fail++;
            $display("FAIL %s err: got err=%b code=%b, required code=%b", name, err, err_code, exp_code);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s core_beats: got %0d beats, required %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s core_beat[%0d]: got last=%b data=%h, required last=%b data=%h",
                         name, i, got_q[i].last, got_q[i].data, exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    task automatic new_frame();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_accept(input string name);
        n_checks++;
        if ({busy, s_axis_tready, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s accept: busy/tready/err=%b, required 110", name, {busy, s_axis_tready, err});
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, err_code, out_words, s_axis_tready, core_valid, core_data, core_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all zero (busy=%b err=%b code=%b tready=%b cv=%b)",
                     busy, err, err_code, s_axis_tready, core_valid);
        end
        rstn = 1'b1;
    endtask

    task automatic test_bad_len();
        logic [9:0] lens[3] = '{10'd0, 10'd801, 10'd1023};
        done_cnt = 0;
        foreach (lens[i]) begin
            do_start(lens[i]);
            n_checks++;
            if ({err, err_code, busy, s_axis_tready} !== 5'b10100) begin
                n_fail++;
                $display("FAIL bad_len_%0d: err/code/busy/tready=%b, required 10100",
                         lens[i], {err, err_code, busy, s_axis_tready});
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_len_quiet: done pulses %0d busy=%b, required 0 and 0", done_cnt, busy);
        end
    endtask

    task automatic test_full_frame();
        int n_done, n_last;
        new_frame();
        do_start(10'd800);
        check_accept("full");
        send_frame(800, 800, 800);
        drain(800, 1'b1, n_done, n_last);
        finish_frame("full", 2'b00, 800, n_done, n_last + 1);
    endtask

    task automatic test_short_frame();
        int n_done, n_last;
        new_frame();
        do_start(10'd4);
        send_frame(2, 2, 2);
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL short_tready: got %b, required 0", s_axis_tready);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        s_axis_tvalid = 1'b0;
        drain(5, 1'b1, n_done, n_last);
        finish_frame("short", 2'b10, 5, n_done, n_last + 1);
    endtask

    task automatic test_timeout();
        int n_done, n_last;
        new_frame();
        do_start(10'd8);
        send_frame(8, 8, 8);
        drain(20, 1'b0, n_done, n_last);
        finish_frame("timeout", 2'b11, 20, n_done, TMO);
    endtask

    task automatic test_start_ignored();
        int n_done, n_last;
        new_frame();
        do_start(10'd6);
        start   = 1'b1;
        cfg_len = 10'd3;
        send_frame(3, 3, 3);
        drain(4, 1'b1, n_done, n_last);
        start = 1'b0;
        finish_frame("start_busy", 2'b10, 4, n_done, n_last + 1);
        new_frame();
        do_start(10'd5);
        check_accept("start_after_done");
        send_frame(5, 5, 5);
        drain(3, 1'b1, n_done, n_last);
        finish_frame("second_frame", 2'b00, 3, n_done, n_last + 1);
    endtask

    task automatic test_random();
        int len, tlast_at, n_fwd, n_out, n_done, n_last;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(40, 1);
            case ($urandom_range(3))
                1:       tlast_at = (len > 1) ? $urandom_range(len - 1, 1) : len;
                2:       tlast_at = 0;
                default: tlast_at = len;
            endcase
            n_fwd = (tlast_at != 0 && tlast_at < len) ? tlast_at : len;
            n_out = $urandom_range(30, 1);
            new_frame();
            do_start(10'(len));
            send_frame(n_fwd, tlast_at, n_fwd);
            drain(n_out, 1'b1, n_done, n_last);
            finish_frame($sformatf("random%0d", it), (tlast_at == len) ? 2'b00 : 2'b10,
                         n_out, n_done, n_last + 1);
        end
    endtask

    task automatic test_reset_midframe();
        int n_done, n_last;
        new_frame();
        do_start(10'd8);
        send_frame(3, 0, 8);
        rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, err_code, out_words, s_axis_tready, core_valid, core_data, core_last} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: outputs not all zero (busy=%b tready=%b cv=%b)",
                     busy, s_axis_tready, core_valid);
        end
        rstn = 1'b1;
        new_frame();
        do_start(10'd8);
        check_accept("after_reset");
        send_frame(8, 8, 8);
        drain(8, 1'b1, n_done, n_last);
        finish_frame("after_reset", 2'b00, 8, n_done, n_last + 1);
    endtask

    initial begin
        start = 1'b0;
        cfg_len = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tlast = 1'b0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast = 1'b0;
        done_cnt = 0;
        test_reset();
        test_bad_len();
        test_full_frame();
        test_short_frame();
        test_timeout();
        test_start_ignored();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
